ofm_packer: RTL

- Width up-converter at the output side of the conv accelerator; mirror of the input-side 512→64 parser.
- Collects narrow 64-bit result beats from the PE array and packs them into 512-bit AXI-Stream words for the output DMA.
- Lane order matches the parser's slicing: the first beat lands in the LSBs, so results round-trip with the same word layout.
- Handles partial final words (keep mask + last), sink back-pressure, and a synchronous soft clear between layers.

---
 rtl/ofm_packer_if.sv | 24 ++
 rtl/ofm_packer.sv | 71 +++++++
 2 files changed

// File: rtl/ofm_packer_if.sv
// ofm_packer_if: narrow result-beat input and packed AXI-Stream output of the packer
interface ofm_packer_if #(
    parameter int IN_WIDTH  = 64,
    parameter int OUT_WIDTH = 512
);
    localparam int KEEP_WIDTH = OUT_WIDTH / 8;
    logic [IN_WIDTH-1:0]   din;
    logic                  din_valid;
    logic                  din_last;
    logic                  din_ready;
    logic [OUT_WIDTH-1:0]  m_tdata;
    logic [KEEP_WIDTH-1:0] m_tkeep;
    logic                  m_tlast;
    logic                  m_tvalid;
    logic                  m_tready;
    modport master (
        input  din, din_valid, din_last, m_tready,
        output din_ready, m_tdata, m_tkeep, m_tlast, m_tvalid
    );
    modport slave (
        output din, din_valid, din_last, m_tready,
        input  din_ready, m_tdata, m_tkeep, m_tlast, m_tvalid
    );
endinterface

// File: rtl/ofm_packer.sv
// ofm_packer: packs IN_WIDTH result beats LSB-first into OUT_WIDTH AXI-Stream words
module ofm_packer #(
    parameter int IN_WIDTH   = 64,
    parameter int OUT_WIDTH  = 512,
    parameter int MAX_CNT    = OUT_WIDTH / IN_WIDTH,
    parameter int KEEP_WIDTH = OUT_WIDTH / 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    ofm_packer_if.master      bus,
    output logic [15:0]       words_out,
    output logic              frame_done
);
    localparam int CW = $clog2(MAX_CNT);
    localparam int LB = IN_WIDTH / 8;
    logic [CW-1:0]         cnt;
    logic [OUT_WIDTH-1:0]  asm_q, word;
    logic [KEEP_WIDTH-1:0] keep;
    logic                  acc, done, hs;
    assign bus.din_ready = !bus.m_tvalid || bus.m_tready;
    assign acc  = bus.din_valid && bus.din_ready;
    assign done = acc && (cnt == CW'(MAX_CNT - 1) || bus.din_last);
    assign hs   = bus.m_tvalid && bus.m_tready;
    // Incoming beat merged into its lane; lanes above it are zeroed so no stale data leaks
    always_comb begin
        word = '0;
        keep = '0;
        for (int i = 0; i < MAX_CNT; i++) begin
            word[i*IN_WIDTH +: IN_WIDTH] = CW'(i) < cnt ? asm_q[i*IN_WIDTH +: IN_WIDTH] :
                                           CW'(i) == cnt ? bus.din : '0;
            keep[i*LB +: LB] = CW'(i) <= cnt ? '1 : '0;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt          <= '0;
            asm_q        <= '0;
            bus.m_tdata  <= '0;
            bus.m_tkeep  <= '0;
            bus.m_tlast  <= 1'b0;
            bus.m_tvalid <= 1'b0;
            words_out    <= '0;
            frame_done   <= 1'b0;
        end else if (clear) begin
            cnt          <= '0;
            asm_q        <= '0;
            bus.m_tkeep  <= '0;
            bus.m_tlast  <= 1'b0;
            bus.m_tvalid <= 1'b0;
            frame_done   <= 1'b0;
        end else begin
            frame_done <= hs && bus.m_tlast;
            if (hs) words_out <= words_out + 16'd1;
            if (done) begin
                cnt          <= '0;
                asm_q        <= '0;
                bus.m_tdata  <= word;
                bus.m_tkeep  <= keep;
                bus.m_tlast  <= bus.din_last;
                bus.m_tvalid <= 1'b1;
            end else begin
                if (acc) begin
                    asm_q <= word;
                    cnt   <= cnt + 1'b1;
                end
                if (hs) bus.m_tvalid <= 1'b0;
            end
        end
    end
endmodule
